rom_dl_ctrl: RTL and testbench
==============================

# rom_dl_ctrl

Download sequencer and ROM write-port arbiter for the debug download path. It sits between the UART download engine, the CPU-side ROM write path and the ROM write port. When a download starts, it holds the CPU and gives the loader exclusive ROM write access. It declares the download finished after an idle timeout, then pulses CPU reset so execution restarts from the new image.

## Interface
- `TIMEOUT_CYCLES`, 1_000_000: idle cycles in LOAD with no loader write before the download is declared complete (20 ms at 50 MHz).
- `RST_CYCLES`, 16: length of the `cpu_rst_o` pulse after a download; must be ≥ 1.
- `clk  in  1`: system clock; the only clock in the block.
- `rst  in  1`: reset, synchronous and active-high.
- `dl_req_i  in  1`: loader bus request; high in the same cycle as `dl_wr_en_i`.
- `dl_wr_en_i  in  1`: loader word-write strobe.
- `dl_addr_i  in  32`: loader write address.
- `dl_data_i  in  32`: loader write data.
- `cpu_we_i  in  1`: CPU ROM write strobe.
- `cpu_addr_i  in  32`: CPU ROM write address.
- `cpu_data_i  in  32`: CPU ROM write data.
- `rom_we_o  out  1`: ROM write enable.
- `rom_addr_o  out  32`: ROM write address.
- `rom_data_o  out  32`: ROM write data.
- `cpu_hold_o  out  1`: CPU stall request.
- `cpu_rst_o  out  1`: CPU reset request, active-high.
- `dl_busy_o  out  1`: high when the state is not RUN.
- `dl_done_o  out  1`: one-cycle pulse when a download completes.
- `word_cnt_o  out  16`: number of words written in the current or last download.

## Operation
- **States:** RUN, LOAD, RELEASE.
- **Loader grant:**
  - `dl_gnt = (state != RUN) | dl_req_i`, combinational.
  - Loader has absolute priority over the CPU.
- **ROM port mux:**
  - When `dl_gnt` is high: `rom_we_o = dl_wr_en_i`, `rom_addr_o = dl_addr_i`, `rom_data_o = dl_data_i`.
  - Otherwise: `rom_*` is driven from `cpu_*`.
  - A CPU write in a cycle with `dl_gnt` high is dropped. `cpu_hold_o` is high in that cycle, so the core must retry.
- **CPU hold:** `cpu_hold_o = dl_gnt`.
- **Accepted write:** `acc = dl_gnt & dl_wr_en_i`.
- **RUN:**
  - `dl_req_i` moves the state to LOAD.
  - `word_cnt` clears to 0, then counts this cycle's `acc`, so the result is 1 if `acc`.
  - Timeout counter clears.
- **LOAD:**
  - Each `acc` increments `word_cnt`, saturating at 0xFFFF, and clears the timeout counter.
  - Otherwise the timeout counter increments.
  - When the counter reaches `TIMEOUT_CYCLES-1` with no `acc`: go to RELEASE, pulse `dl_done_o`, clear the release counter.
- **RELEASE:**
  - `cpu_rst_o` is high; `cpu_hold_o` stays high.
  - The release counter counts up; at `RST_CYCLES-1` the state goes to RUN.
  - If `dl_req_i` arrives: return to LOAD, accept the write, keep `word_cnt` (continued download, not cleared), clear the timeout counter.
  - `cpu_rst_o` drops in the cycle of that return.
- **Counter widths:** sized with `$clog2` of their parameter. The timeout counter never wraps because it is compared before incrementing.
- **Reset:**
  - State goes to RUN and all counters clear.
  - Registered outputs go to 0: `cpu_rst_o=0`, `dl_done_o=0`, `word_cnt_o=0`, `dl_busy_o=0`.
  - Combinational outputs follow their inputs.
  - Reset in mid-LOAD abandons the download; the CPU is not reset by this block.

## Timing
- Zero-latency pass-through on the ROM port. The first loader word, arriving in RUN, is written in the same cycle as its request.
- `dl_busy_o` rises one cycle after the first `dl_req_i`.
- A download ends exactly `TIMEOUT_CYCLES` cycles after the last accepted write:
  - `dl_done_o` is high in the first RELEASE cycle.
  - `cpu_rst_o` is high for exactly `RST_CYCLES` cycles, starting in that same cycle.
  - `cpu_hold_o` and `dl_busy_o` fall in the cycle RUN is entered.
- `cpu_rst_o`, `dl_done_o`, `dl_busy_o` and `word_cnt_o` are registered (Moore, decoded from state or flops).

## Structure
- State encodings (2-bit) go in `defines.v` as `DL_RUN`, `DL_LOAD`, `DL_RELEASE`, alongside the existing bus-width macros. `INST_ADDR_BUS` and `INST_DATA_BUS` are used for the 32-bit ports.
- Single module; no sub-module. The three counters are small enough to stay inline.

## Test plan
Bench parameters: `TIMEOUT_CYCLES=100`, `RST_CYCLES=4`.
- **Idle CPU path:** CPU write to 0x10 with data 0xDEADBEEF while idle → `rom_we_o=1`, addr 0x10, data 0xDEADBEEF, same cycle; `cpu_hold_o=0`.
- **First-word collision:** loader writes word 0x00000013 to addr 0 in the same cycle as a CPU write → ROM receives the loader word; CPU write dropped; `cpu_hold_o=1`; `dl_busy_o=1` next cycle; `word_cnt_o=1`.
- **Full download:** 8 loader writes spaced 60 cycles apart, then silence → `word_cnt_o=8`; `dl_done_o` pulses 100 cycles after the 8th write; `cpu_rst_o` high 4 cycles; then RUN with `cpu_hold_o=0`.
- **Restart in RELEASE:** loader write in the 2nd RELEASE cycle → back to LOAD; `cpu_rst_o` drops that cycle; `word_cnt_o` increments from 8 to 9.
- **Timeout boundary:** loader write exactly at timeout count 99 → no `dl_done_o`; counter restarts.
- **Reset mid-LOAD:** `rst` asserted after 3 words → next cycle shows RUN state, `word_cnt_o=0`, `cpu_rst_o=0`, `dl_busy_o=0`.

Source files
------------

// File: rtl/rom_dl_ctrl_pkg.sv
// Shared types for the download sequencer: FSM state encoding, bus widths, helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rom_dl_ctrl_pkg;

  localparam int INST_ADDR_BUS = 32;
  localparam int INST_DATA_BUS = 32;
  localparam int WORD_CNT_W    = 16;

  typedef enum logic [1:0] {
    DL_RUN     = 2'd0,
    DL_LOAD    = 2'd1,
    DL_RELEASE = 2'd2
  } dl_state_e;

  // Word counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [WORD_CNT_W-1:0] sat_inc(input logic [WORD_CNT_W-1:0] v,
                                                    input logic                  en);
    if (en && (v != {WORD_CNT_W{1'b1}}))
      return v + 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rom_dl_ctrl.sv
// Download sequencer + ROM write-port arbiter: loader preempts CPU, idle timeout ends a download, then CPU reset pulse.
// Latency: ROM port mux and cpu_hold_o are zero-latency; busy/done/cpu_rst/word_cnt are registered (one cycle).
// Backpressure: CPU writes colliding with the loader grant are dropped while cpu_hold_o is high; the core must retry.
module rom_dl_ctrl
  import rom_dl_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int RST_CYCLES     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dl_req_i,
  input  logic                     dl_wr_en_i,
  input  logic [INST_ADDR_BUS-1:0] dl_addr_i,
  input  logic [INST_DATA_BUS-1:0] dl_data_i,
  input  logic                     cpu_we_i,
  input  logic [INST_ADDR_BUS-1:0] cpu_addr_i,
  input  logic [INST_DATA_BUS-1:0] cpu_data_i,
  output logic                     rom_we_o,
  output logic [INST_ADDR_BUS-1:0] rom_addr_o,
  output logic [INST_DATA_BUS-1:0] rom_data_o,
  output logic                     cpu_hold_o,
  output logic                     cpu_rst_o,
  output logic                     dl_busy_o,
  output logic                     dl_done_o,
  output logic [WORD_CNT_W-1:0]    word_cnt_o
);

  // Counter widths come from their terminal counts; a floor of 1 bit keeps
  // degenerate parameter values (e.g. RST_CYCLES=1) legal.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] R_LAST = RW'(RST_CYCLES - 1);

  dl_state_e               r_state;
  dl_state_e               w_state_nxt;
  logic [TW-1:0]           r_tcnt;
  logic [TW-1:0]           w_tcnt_nxt;
  logic [RW-1:0]           r_rcnt;
  logic [RW-1:0]           w_rcnt_nxt;
  logic [WORD_CNT_W-1:0]   r_wcnt;
  logic [WORD_CNT_W-1:0]   w_wcnt_nxt;
  logic                    r_done;
  logic                    w_done_nxt;
  logic                    w_dl_gnt;
  logic                    w_acc;

  // Loader owns the ROM port outside RUN, and in RUN as soon as it requests.
  assign w_dl_gnt = (r_state != DL_RUN) | dl_req_i;
  assign w_acc    = w_dl_gnt & dl_wr_en_i;

  // ROM port: loader has absolute priority, otherwise CPU passes straight through.
  assign rom_we_o   = w_dl_gnt ? dl_wr_en_i : cpu_we_i;
  assign rom_addr_o = w_dl_gnt ? dl_addr_i  : cpu_addr_i;
  assign rom_data_o = w_dl_gnt ? dl_data_i  : cpu_data_i;
  assign cpu_hold_o = w_dl_gnt;

  // Moore outputs decoded from the state register and flops.
  assign cpu_rst_o  = (r_state == DL_RELEASE);
  assign dl_busy_o  = (r_state != DL_RUN);
  assign dl_done_o  = r_done;
  assign word_cnt_o = r_wcnt;

  // Next-state and counter update logic; the timeout counter is compared
  // before it is incremented, so it never wraps.
  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_nxt  = r_tcnt;
    w_rcnt_nxt  = r_rcnt;
    w_wcnt_nxt  = r_wcnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      DL_RUN: begin
        w_tcnt_nxt = '0;
        if (dl_req_i) begin
          // New download: count restarts and includes this cycle's word.
          w_state_nxt = DL_LOAD;
          w_wcnt_nxt  = {{(WORD_CNT_W-1){1'b0}}, w_acc};
        end
      end
      DL_LOAD: begin
        if (w_acc) begin
          w_wcnt_nxt = sat_inc(r_wcnt, 1'b1);
          w_tcnt_nxt = '0;
        end else if (r_tcnt == T_LAST) begin
          w_state_nxt = DL_RELEASE;
          w_done_nxt  = 1'b1;
          w_rcnt_nxt  = '0;
        end else begin
          w_tcnt_nxt = r_tcnt + 1'b1;
        end
      end
      DL_RELEASE: begin
        if (dl_req_i) begin
          // Late words continue the same download: count is kept.
          w_state_nxt = DL_LOAD;
          w_wcnt_nxt  = sat_inc(r_wcnt, w_acc);
          w_tcnt_nxt  = '0;
        end else if (r_rcnt == R_LAST) begin
          w_state_nxt = DL_RUN;
        end else begin
          w_rcnt_nxt = r_rcnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = DL_RUN;
      end
    endcase
  end

  // State and counter registers with synchronous reset; reset abandons any download.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DL_RUN;
      r_tcnt  <= '0;
      r_rcnt  <= '0;
      r_wcnt  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_rcnt  <= w_rcnt_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_rom_dl_ctrl.sv
// Self-checking bench for rom_dl_ctrl: directed stimulus pushes expectations, a negedge monitor consumes them.
// Latency: expectations are tagged with the cycle they apply to.
// Backpressure: n/a.
module tb_rom_dl_ctrl;

  localparam int TO  = 100;
  localparam int RSC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        dl_req, dl_wr_en, cpu_we;
  logic [31:0] dl_addr, dl_data, cpu_addr, cpu_data;
  logic        rom_we, cpu_hold, cpu_rst, dl_busy, dl_done;
  logic [31:0] rom_addr, rom_data;
  logic [15:0] word_cnt;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int          c;
    int          id;
    logic [31:0] v;
    string       nm;
  } exp_t;
  exp_t q[$];

  rom_dl_ctrl #(.TIMEOUT_CYCLES(TO), .RST_CYCLES(RSC)) dut (
    .clk(clk), .rst(rst),
    .dl_req_i(dl_req), .dl_wr_en_i(dl_wr_en), .dl_addr_i(dl_addr), .dl_data_i(dl_data),
    .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_data),
    .rom_we_o(rom_we), .rom_addr_o(rom_addr), .rom_data_o(rom_data),
    .cpu_hold_o(cpu_hold), .cpu_rst_o(cpu_rst), .dl_busy_o(dl_busy),
    .dl_done_o(dl_done), .word_cnt_o(word_cnt)
  );

  always #5 clk = ~clk;

  // Cycle index: inputs driven after posedge N+... belong to cycle cyc.
  always @(posedge clk) cyc <= cyc + 1;

  localparam int S_WE = 0, S_ADDR = 1, S_DATA = 2, S_HOLD = 3,
                 S_RST = 4, S_BUSY = 5, S_DONE = 6, S_WCNT = 7;

  function automatic logic [31:0] get_sig(input int id);
    case (id)
      S_WE:   return {31'b0, rom_we};
      S_ADDR: return rom_addr;
      S_DATA: return rom_data;
      S_HOLD: return {31'b0, cpu_hold};
      S_RST:  return {31'b0, cpu_rst};
      S_BUSY: return {31'b0, dl_busy};
      S_DONE: return {31'b0, dl_done};
      S_WCNT: return {16'b0, word_cnt};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic expect_at(input int c, input int id, input logic [31:0] v, input string nm);
    exp_t e;
    e.c = c; e.id = id; e.v = v; e.nm = nm;
    q.push_back(e);
  endtask

  // Monitor: consume every expectation due this cycle; flag any left behind.
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].c == cyc) begin
        n_checks++;
        if (get_sig(q[i].id) !== q[i].v) begin
          n_fail++;
          $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", q[i].nm, cyc, get_sig(q[i].id), q[i].v);
        end
        q.delete(i);
      end else if (q[i].c < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL stale_%s due=%0d now=%0d got=0x%0h want=0x%0h", q[i].nm, q[i].c, cyc, 32'h0, q[i].v);
        q.delete(i);
      end
    end
  end

  task automatic drive(input logic r, input logic req, input logic we,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic cwe, input logic [31:0] ca, input logic [31:0] cd);
    @(posedge clk);
    #1;
    rst = r; dl_req = req; dl_wr_en = we; dl_addr = a; dl_data = d;
    cpu_we = cwe; cpu_addr = ca; cpu_data = cd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic ld_wr(input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, 1'b1, 1'b1, a, d, 1'b0, 32'h0, 32'h0);
  endtask

  // Idle until the next drive lands in cycle t.
  task automatic idle_until(input int t);
    while (cyc < t - 1) idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1);
  end

  initial begin
    int c, w, w2, r;
    rst = 1'b1; dl_req = 1'b0; dl_wr_en = 1'b0; dl_addr = '0; dl_data = '0;
    cpu_we = 1'b0; cpu_addr = '0; cpu_data = '0;
    repeat (3) drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);

    // Reset state.
    idle(); c = cyc;
    expect_at(c, S_BUSY, 0, "rst_busy");
    expect_at(c, S_RST,  0, "rst_cpu_rst");
    expect_at(c, S_DONE, 0, "rst_done");
    expect_at(c, S_WCNT, 0, "rst_wcnt");
    expect_at(c, S_HOLD, 0, "rst_hold");
    expect_at(c, S_WE,   0, "rst_rom_we");

    // Idle CPU path: same-cycle pass-through, no hold.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h10, 32'hDEADBEEF); c = cyc;
    expect_at(c, S_WE,   1, "cpu_we");
    expect_at(c, S_ADDR, 32'h10, "cpu_addr");
    expect_at(c, S_DATA, 32'hDEADBEEF, "cpu_data");
    expect_at(c, S_HOLD, 0, "cpu_nohold");
    idle();
    expect_at(c + 1, S_BUSY, 0, "cpu_nobusy");

    // First-word collision: loader wins, CPU held.
    drive(1'b0, 1'b1, 1'b1, 32'h0, 32'h13, 1'b1, 32'h20, 32'h55); c = cyc;
    expect_at(c, S_WE,   1, "col_we");
    expect_at(c, S_ADDR, 32'h0, "col_addr");
    expect_at(c, S_DATA, 32'h13, "col_data");
    expect_at(c, S_HOLD, 1, "col_hold");
    expect_at(c, S_BUSY, 0, "col_busy_now");
    expect_at(c + 1, S_BUSY, 1, "col_busy_next");
    expect_at(c + 1, S_WCNT, 1, "col_wcnt");

    // Full download: 7 more words 60 cycles apart.
    for (int k = 1; k < 8; k++) begin
      idle_until(c + 60);
      ld_wr(32'(4 * k), 32'h13 + 32'(k)); c = cyc;
      expect_at(c + 1, S_WCNT, 32'(k + 1), "dl_wcnt");
      expect_at(c + 1, S_DONE, 0, "dl_nodone");
    end
    w = c;
    // Done rises on the 100th edge after the edge accepting the last word.
    expect_at(w + TO,     S_DONE, 0, "to_done_early");
    expect_at(w + TO,     S_RST,  0, "to_rst_early");
    expect_at(w + TO + 1, S_DONE, 1, "to_done");
    expect_at(w + TO + 1, S_RST,  1, "to_rst_first");
    expect_at(w + TO + 2, S_DONE, 0, "to_done_pulse");
    expect_at(w + TO + RSC,     S_RST,  1, "to_rst_last");
    expect_at(w + TO + RSC,     S_HOLD, 1, "to_hold_last");
    expect_at(w + TO + RSC,     S_BUSY, 1, "to_busy_last");
    expect_at(w + TO + RSC + 1, S_RST,  0, "to_rst_end");
    expect_at(w + TO + RSC + 1, S_HOLD, 0, "to_hold_end");
    expect_at(w + TO + RSC + 1, S_BUSY, 0, "to_busy_end");
    expect_at(w + TO + RSC + 1, S_WCNT, 8, "to_wcnt_kept");
    idle_until(w + TO + RSC + 3);

    // Second download of 8 words, then restart in the 2nd RELEASE cycle.
    for (int k = 0; k < 8; k++) begin
      ld_wr(32'h100 + 32'(4 * k), 32'hA000 + 32'(k)); c = cyc;
      idle();
    end
    w2 = c;
    expect_at(w2 + 1, S_WCNT, 8, "dl2_wcnt");
    idle_until(w2 + TO + 1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h40, 32'h77); c = cyc;
    expect_at(c, S_WE,   0, "rel_cpu_drop");
    expect_at(c, S_HOLD, 1, "rel_hold");
    expect_at(c, S_DONE, 1, "rel_done");
    ld_wr(32'h200, 32'hA5A5); r = cyc;
    expect_at(r, S_WE,   1, "rs_we");
    expect_at(r, S_ADDR, 32'h200, "rs_addr");
    expect_at(r, S_RST,  1, "rs_rst_now");
    expect_at(r + 1, S_RST,  0, "rs_rst_drop");
    expect_at(r + 1, S_WCNT, 9, "rs_wcnt");
    expect_at(r + 1, S_BUSY, 1, "rs_busy");
    expect_at(r + 1, S_DONE, 0, "rs_nodone");

    // Timeout boundary: word lands exactly at count TO-1.
    idle_until(r + TO);
    ld_wr(32'h204, 32'h5A5A);
    expect_at(r + TO + 1, S_DONE, 0, "tb_nodone");
    expect_at(r + TO + 1, S_RST,  0, "tb_norst");
    expect_at(r + TO + 1, S_WCNT, 10, "tb_wcnt");
    expect_at(r + 2 * TO,     S_DONE, 0, "tb_done_early");
    expect_at(r + 2 * TO + 1, S_DONE, 1, "tb_done_restart");
    expect_at(r + 2 * TO + RSC + 1, S_BUSY, 0, "tb_busy_end");
    idle_until(r + 2 * TO + RSC + 3);

    // Reset in mid-LOAD after 3 words.
    ld_wr(32'h0, 32'h1);
    ld_wr(32'h4, 32'h2);
    ld_wr(32'h8, 32'h3); c = cyc;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    expect_at(c + 1, S_WCNT, 3, "mr_wcnt_pre");
    expect_at(c + 1, S_BUSY, 1, "mr_busy_pre");
    idle();
    expect_at(c + 2, S_BUSY, 0, "mr_busy");
    expect_at(c + 2, S_WCNT, 0, "mr_wcnt");
    expect_at(c + 2, S_RST,  0, "mr_cpu_rst");
    expect_at(c + 2, S_HOLD, 0, "mr_hold");
    repeat (3) idle();

    @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expectations got=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
